// File: rtl/pipelined_barrel_shifter.sv
// Pipelined logarithmic barrel shifter (SLL/SRL/SRA/ROR) carrying an opaque tag with each operation.
// Latency: NUM_SLOT cycles from accept to out_valid when unstalled (3 at WIDTH=32, REG_EVERY=2).
// Backpressure: per-slot valid/ready; bubbles collapse, in_ready drops only when every slot is full and the output stalls.
module pipelined_barrel_shifter #(
    parameter int WIDTH     = 32,
    parameter int SHAMT_W   = $clog2(WIDTH),
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
);
    localparam int NUM_SLOT = (SHAMT_W + REG_EVERY - 1) / REG_EVERY;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef struct packed {
        logic [WIDTH-1:0]   dat;
        logic [SHAMT_W-1:0] shamt;
        logic [1:0]         op;
        logic               sign;
        logic [TAG_W-1:0]   tag;
    } slot_t;

    logic [NUM_SLOT-1:0] vld_q;
    logic [NUM_SLOT-1:0] src_vld;
    logic [NUM_SLOT-1:0] load;
    slot_t               slot_q [NUM_SLOT];
    slot_t               slot_d [NUM_SLOT];
    slot_t               src    [NUM_SLOT];

    // One mux level: shift by 2^k. SRA fills with the operand's original sign bit.
    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input int               k,
        input logic [1:0]       op,
        input logic             sign
    );
        int sh;
        sh = 1 << k;
        case (op)
            OP_SLL:  return d << sh;
            OP_SRL:  return d >> sh;
            OP_SRA:  return (d >> sh) | (sign ? ~({WIDTH{1'b1}} >> sh) : {WIDTH{1'b0}});
            default: return (d >> sh) | (d << (WIDTH - sh));
        endcase
    endfunction

    // A slot may load if any slot at or downstream of it is empty, or the output is draining.
    always_comb begin : p_load
        logic free;
        free = out_ready;
        load = '0;
        for (int s = NUM_SLOT - 1; s >= 0; s--) begin
            free    = free | ~vld_q[s];
            load[s] = free;
        end
    end

    always_comb begin : p_datapath
        slot_t cur;
        src_vld[0] = in_valid;
        src[0]     = '{dat: in_data, shamt: in_shamt, op: in_op,
                       sign: in_data[WIDTH-1], tag: in_tag};
        for (int s = 1; s < NUM_SLOT; s++) begin
            src_vld[s] = vld_q[s-1];
            src[s]     = slot_q[s-1];
        end
        for (int s = 0; s < NUM_SLOT; s++) begin
            cur = src[s];
            for (int k = 0; k < SHAMT_W; k++) begin
                if ((k / REG_EVERY) == s && cur.shamt[k]) begin
                    cur.dat = shift_level(cur.dat, k, cur.op, cur.sign);
                end
            end
            slot_d[s] = cur;
        end
    end

    // Payload only loads with a valid op, so an idle input never disturbs held state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int s = 0; s < NUM_SLOT; s++) begin
                slot_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SLOT; s++) begin
                if (load[s]) begin
                    vld_q[s] <= src_vld[s];
                    if (src_vld[s]) begin
                        slot_q[s] <= slot_d[s];
                    end
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = vld_q[NUM_SLOT-1];
    assign out_data  = slot_q[NUM_SLOT-1].dat;
    assign out_tag   = slot_q[NUM_SLOT-1].tag;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed-vector and scoreboard bench for pipelined_barrel_shifter at WIDTH=32, REG_EVERY=2, TAG_W=4.
module tb_pipelined_barrel_shifter;
    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_tag;

    pipelined_barrel_shifter #(
        .WIDTH(32), .REG_EVERY(2), .TAG_W(4)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] dat;
        logic [4:0]  sh;
        logic [3:0]  tag;
        logic [31:0] exp;
    } vec_t;

    typedef struct packed {
        logic [31:0] dat;
        logic [3:0]  tag;
    } exp_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];
    exp_t sb_q [$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   n_out = 0;
    int   run3, t3, acc, idx, base_out, cyc;
    logic pend;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                              input logic [4:0] sh);
        logic [63:0] dd;
        case (op)
            2'd0:    return d << sh;
            2'd1:    return d >> sh;
            2'd2:    return $unsigned($signed(d) >>> sh);
            default: begin
                dd = {d, d} >> sh;
                return dd[31:0];
            end
        endcase
    endfunction

    // Scoreboard: expected results are queued at accept and popped in order at output handshake.
    always @(negedge clock) begin
        if (reset_n) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_out", 32'(sb_q.size()), 32'd1);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("sb_data", out_data, mon_e.dat);
                    chk("sb_tag", 32'(out_tag), 32'(mon_e.tag));
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back('{dat: ref_shift(in_op, in_data, in_shamt), tag: in_tag});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh,
                        input logic [3:0] tag);
        int t;
        t = 0;
        in_valid = 1'b1; in_op = op; in_data = d; in_shamt = sh; in_tag = tag;
        @(negedge clock);
        while (!in_ready && t < 100) begin
            @(posedge clock); #1;
            @(negedge clock);
            t++;
        end
        if (!in_ready) chk("send_accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        lat = 0;
        out_ready = 1'b1;
        send(v.op, v.dat, v.sh, v.tag);
        do begin
            @(negedge clock);
            lat++;
        end while (!out_valid && lat < 20);
        chk({name, "_latency"}, lat, 32'd3);
        chk({name, "_data"}, out_data, v.exp);
        chk({name, "_tag"}, 32'(out_tag), 32'(v.tag));
        @(posedge clock); #1;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while ((sb_q.size() != 0 || out_valid) && t < 200) begin
            @(posedge clock); #1;
            t++;
        end
        chk(name, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{2'd2, 32'h8000_0000, 5'd4,  4'd3,  32'hF800_0000};
        vecs[1]  = '{2'd1, 32'h8000_0000, 5'd4,  4'd4,  32'h0800_0000};
        vecs[2]  = '{2'd0, 32'h0000_0001, 5'd31, 4'd5,  32'h8000_0000};
        vecs[3]  = '{2'd3, 32'h0000_0001, 5'd1,  4'd6,  32'h8000_0000};
        vecs[4]  = '{2'd3, 32'h1234_5678, 5'd8,  4'd7,  32'h7812_3456};
        vecs[5]  = '{2'd0, 32'hDEAD_BEEF, 5'd0,  4'd8,  32'hDEAD_BEEF};
        vecs[6]  = '{2'd1, 32'hDEAD_BEEF, 5'd0,  4'd9,  32'hDEAD_BEEF};
        vecs[7]  = '{2'd2, 32'hDEAD_BEEF, 5'd0,  4'd10, 32'hDEAD_BEEF};
        vecs[8]  = '{2'd3, 32'hDEAD_BEEF, 5'd0,  4'd11, 32'hDEAD_BEEF};
        vecs[9]  = '{2'd2, 32'h8000_0000, 5'd31, 4'd12, 32'hFFFF_FFFF};
        vecs[10] = '{2'd2, 32'h7FFF_FFFF, 5'd31, 4'd13, 32'h0000_0000};
        vecs[11] = '{2'd3, 32'h8000_0001, 5'd31, 4'd14, 32'h0000_0003};
        vecs[12] = '{2'd0, 32'h0000_FFFF, 5'd4,  4'd15, 32'h000F_FFF0};
        vecs[13] = '{2'd1, 32'hF000_0000, 5'd28, 4'd0,  32'h0000_000F};
        vecs[14] = '{2'd2, 32'h8000_0000, 5'd16, 4'd1,  32'hFFFF_8000};
        vecs[15] = '{2'd3, 32'h0000_000F, 5'd4,  4'd2,  32'hF000_0000};
        vecs[16] = '{2'd0, 32'hDEAD_BEEF, 5'd16, 4'd3,  32'hBEEF_0000};
        vecs[17] = '{2'd3, 32'hABCD_1234, 5'd16, 4'd4,  32'h1234_ABCD};

        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0;
        in_op = '0; in_tag = '0; out_ready = 1'b0;
        #2;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_data", out_data, 32'd0);
        chk("reset_out_tag", 32'(out_tag), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;

        // Single ops: hand-computed results, tag return and 3-cycle latency.
        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // 16 back-to-back ops with tags 0..15 and no backpressure.
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    send(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), 4'(i));
                end
            end
            begin
                t3 = 0; run3 = 0;
                @(negedge clock);
                while (!out_valid && t3 < 50) begin
                    @(negedge clock);
                    t3++;
                end
                while (out_valid && run3 < 40) begin
                    run3++;
                    @(negedge clock);
                end
            end
        join
        @(posedge clock); #1;
        chk("b2b_consecutive_valid", run3, 32'd16);
        drain("b2b_drained");

        // Stall: five ops offered against a blocked output.
        out_ready = 1'b0;
        base_out  = n_out;
        acc = 0; idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1; in_op = 2'd0; in_data = 32'h11;
            in_shamt = 5'(idx); in_tag = 4'(idx + 8);
            @(negedge clock);
            if (in_ready) begin
                acc++;
                idx++;
            end
            @(posedge clock); #1;
        end
        chk("stall_accepted", acc, 32'd3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_data", out_data, 32'h11);
            chk("stall_out_tag", 32'(out_tag), 32'd8);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        send(2'd0, 32'h11, 5'd3, 4'd11);
        send(2'd0, 32'h11, 5'd4, 4'd12);
        drain("stall_drained");
        chk("stall_result_count", n_out - base_out, 32'd5);

        // Random valid/ready over 2000 ops.
        acc = 0; cyc = 0; pend = 1'b0;
        while (acc < 2000 && cyc < 40000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (!pend && ($urandom_range(0, 1) == 1)) begin
                in_op = 2'($urandom_range(0, 3)); in_data = $urandom;
                in_shamt = 5'($urandom_range(0, 31)); in_tag = 4'(acc);
                pend = 1'b1;
            end
            in_valid = pend;
            @(negedge clock);
            if (pend && in_ready) begin
                pend = 1'b0;
                acc++;
            end
            @(posedge clock); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("rand_accepts", acc, 32'd2000);
        drain("rand_drained");

        // Reset with three ops in flight.
        out_ready = 1'b0;
        send(2'd0, 32'h1, 5'd1, 4'd1);
        send(2'd0, 32'h1, 5'd2, 4'd2);
        send(2'd0, 32'h1, 5'd3, 4'd3);
        chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_in_ready", 32'(in_ready), 32'd1);
        chk("midreset_out_data", out_data, 32'd0);
        sb_q.delete();
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        run_vec('{2'd2, 32'hFFFF_FFF0, 5'd31, 4'd5, 32'hFFFF_FFFF}, "post_reset_sra");
        drain("post_reset_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
